// File: rtl/reg8_scan_src.sv
// Register bank plus handshaked scan sequencer feeding the 8:1 word mux select.
// Optional build macro SCAN_SKIP_ZERO_EN: the scan only presents indices whose register is nonzero.
module reg8_scan_src #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3,
  localparam int NREG = 1 << SEL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [SEL_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    stop,
  output logic [NREG*WIDTH-1:0]   r_flat,
  output logic [SEL_W-1:0]        sel,
  output logic                    sel_valid,
  input  logic                    sel_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NREG - 1);

  logic [WIDTH-1:0] bank_q [NREG];
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             accept;
  logic             fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else if (wr_en) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign r_flat[g*WIDTH +: WIDTH] = bank_q[g];
  end

`ifdef SCAN_SKIP_ZERO_EN
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } hit_t;

  // First nonzero index at or after 'from'; without wrap the search stops at NREG-1.
  function automatic hit_t find_nz(input logic [NREG*WIDTH-1:0] b,
                                   input logic [SEL_W-1:0] from,
                                   input logic wrap);
    hit_t h;
    int   s;
    h = '0;
    for (int k = 0; k < NREG; k++) begin
      s = int'(from) + k;
      if (!h.found && (wrap || s < NREG) && b[(s % NREG)*WIDTH +: WIDTH] != '0) begin
        h.found = 1'b1;
        h.idx   = SEL_W'(s % NREG);
      end
    end
    return h;
  endfunction

  hit_t hit;
`endif

  assign accept = vld_q & sel_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef SCAN_SKIP_ZERO_EN
    hit     = '0;
`endif
    unique case (state_q)
      IDLE: begin
        vld_d  = 1'b0;
        stop_d = 1'b0;
        if (start) begin
          cont_d = cont;
          sel_d  = '0;
`ifdef SCAN_SKIP_ZERO_EN
          hit = find_nz(r_flat, '0, 1'b0);
          if (hit.found) begin
            sel_d   = hit.idx;
            vld_d   = 1'b1;
            state_d = SCAN;
          end else if (cont) begin
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
`else
          vld_d   = 1'b1;
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (stop) stop_d = 1'b1;
        if (accept) begin
          // A stop seen on the accepting edge still lets that beat count.
          if (stop_q || stop) begin
            fin = 1'b1;
          end else if (sel_q == LAST && !cont_q) begin
            fin = 1'b1;
          end else begin
`ifdef SCAN_SKIP_ZERO_EN
            hit = find_nz(r_flat, sel_q + SEL_W'(1), cont_q);
            if (hit.found) begin
              sel_d = hit.idx;
            end else if (cont_q) begin
              sel_d = '0;
              vld_d = 1'b0;
            end else begin
              fin = 1'b1;
            end
`else
            sel_d = sel_q + SEL_W'(1);
`endif
          end
        end
`ifdef SCAN_SKIP_ZERO_EN
        else if (!vld_q) begin
          // Continuous scan over an all-zero bank: idle in SCAN until a word appears or stop.
          if (stop_q || stop) begin
            fin = 1'b1;
          end else begin
            hit = find_nz(r_flat, sel_q, 1'b1);
            if (hit.found) begin
              sel_d = hit.idx;
              vld_d = 1'b1;
            end
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      sel_d   = '0;
      vld_d   = 1'b0;
      stop_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = vld_q;
  assign busy      = (state_q == SCAN);
  assign done      = done_q;

endmodule

// File: tb/tb_reg8_scan_src.sv
// Scoreboard bench for reg8_scan_src: stimulus queues expected {sel, word}; a negedge monitor checks accepts.
module tb_reg8_scan_src;

  localparam int WIDTH = 16;
  localparam int SEL_W = 3;
  localparam int NREG  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  wr_en;
  logic [SEL_W-1:0]      wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  start, cont, stop;
  logic [NREG*WIDTH-1:0] r_flat;
  logic [SEL_W-1:0]      sel;
  logic                  sel_valid, sel_ready, busy, done;

  reg8_scan_src #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .cont(cont), .stop(stop), .r_flat(r_flat), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  logic [SEL_W+WIDTH-1:0] expq[$];
  logic [WIDTH-1:0] model [NREG];
  logic             hold_pend = 1'b0;
  logic [SEL_W-1:0] hold_sel = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: counts valid/done cycles, checks sel hold under back-pressure and accepted words.
  always @(negedge clk) begin
    logic [SEL_W+WIDTH-1:0] e;
    if (done) done_cnt++;
    if (rst_n) begin
      if (sel_valid) vld_cnt++;
      if (done) chk("done_with_valid", {63'd0, sel_valid}, 64'd0);
      if (hold_pend) chk("sel_hold", {61'd0, sel}, {61'd0, hold_sel});
      if (sel_valid && sel_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", {61'd0, sel}, 64'hFFFF);
        end else begin
          e = expq.pop_front();
          chk("beat_sel", {61'd0, sel}, {61'd0, e[SEL_W+WIDTH-1:WIDTH]});
          chk("beat_word", {48'd0, r_flat[int'(sel)*WIDTH +: WIDTH]}, {48'd0, e[WIDTH-1:0]});
        end
      end
      hold_pend = sel_valid && !sel_ready;
      hold_sel  = sel;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = SEL_W'(a); wr_data = d;
    model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(input int a, input logic [WIDTH-1:0] d);
    expq.push_back({SEL_W'(a), d});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  task automatic go(input logic c);
    start = 1'b1; cont = c;
    tick();
    start = 1'b0; cont = 1'b0;
  endtask

  int d0, v0;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; cont = 1'b0; stop = 1'b0; sel_ready = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    #2;
    chk("rst_sel", {61'd0, sel}, 64'd0);
    chk("rst_valid", {63'd0, sel_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bank", r_flat[63:0] | r_flat[127:64], 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: single pass, ready held high
    for (int i = 0; i < NREG; i++) wr(i, 16'h1110 + WIDTH'(i));
    for (int i = 0; i < NREG; i++) push(i, model[i]);
    d0 = done_cnt; v0 = vld_cnt;
    sel_ready = 1'b1;
    go(1'b0);
    chk("t1_latency_valid", {63'd0, sel_valid}, 64'd1);
    chk("t1_first_sel", {61'd0, sel}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      tick();
    end
    start = 1'b0;
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_busy_fall", {63'd0, busy}, 64'd0);
    tick();
    chk("t1_done_pulse", {63'd0, done}, 64'd0);
    chk("t1_vld_cycles", 64'(vld_cnt - v0), 64'd8);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_queue_empty", 64'(expq.size()), 64'd0);

    // Test 2: ready toggling 0,1,0,1 after the first valid cycle
    for (int i = 0; i < NREG; i++) push(i, model[i]);
    d0 = done_cnt;
    go(1'b0);
    for (int i = 0; i < 16; i++) begin
      sel_ready = (i % 2) == 1;
      tick();
    end
    chk("t2_done_16", {63'd0, done}, 64'd1);
    sel_ready = 1'b1;
    tick();
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t2_queue_empty", 64'(expq.size()), 64'd0);

    // Test 3: stop in IDLE is ignored, then continuous scan stopped at sel=3 of the second pass
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_idle_stop", {63'd0, busy}, 64'd0);
    for (int i = 0; i < NREG; i++) push(i, model[i]);
    for (int i = 0; i < 4; i++) push(i, model[i]);
    d0 = done_cnt; v0 = vld_cnt;
    go(1'b1);
    repeat (11) tick();
    chk("t3_sel_before_stop", {61'd0, sel}, 64'd3);
    chk("t3_busy_cont", {63'd0, busy}, 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_valid_off", {63'd0, sel_valid}, 64'd0);
    chk("t3_done", {63'd0, done}, 64'd1);
    tick();
    chk("t3_vld_cycles", 64'(vld_cnt - v0), 64'd12);
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t3_queue_empty", 64'(expq.size()), 64'd0);

    // Test 4: overwrite the presented register under back-pressure
    for (int i = 0; i < 3; i++) push(i, model[i]);
    push(3, 16'hBEEF);
    for (int i = 4; i < NREG; i++) push(i, model[i]);
    go(1'b0);
    repeat (3) tick();
    sel_ready = 1'b0;
    wr(3, 16'hBEEF);
    chk("t4_slice3", {48'd0, r_flat[3*WIDTH +: WIDTH]}, 64'hBEEF);
    chk("t4_sel_hold", {61'd0, sel}, 64'd3);
    chk("t4_valid_hold", {63'd0, sel_valid}, 64'd1);
    sel_ready = 1'b1;
    wait_done(20, "t4_done_timeout");
    tick();
    chk("t4_queue_empty", 64'(expq.size()), 64'd0);

    // Test 5: asynchronous reset mid-scan at sel=5
    for (int i = 0; i < 5; i++) push(i, model[i]);
    go(1'b1);
    repeat (5) tick();
    chk("t5_sel5", {61'd0, sel}, 64'd5);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_sel", {61'd0, sel}, 64'd0);
    chk("t5_valid", {63'd0, sel_valid}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_bank", r_flat[63:0] | r_flat[127:64], 64'd0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_queue_empty", 64'(expq.size()), 64'd0);

    // Test 6: sparse bank (regs 2 and 6 nonzero)
    wr(2, 16'h2222);
    wr(6, 16'h6666);
    v0 = vld_cnt;
`ifdef SCAN_SKIP_ZERO_EN
    push(2, 16'h2222);
    push(6, 16'h6666);
    go(1'b0);
    chk("t6_first_sel", {61'd0, sel}, 64'd2);
    wait_done(10, "t6_done_timeout");
    tick();
    chk("t6_vld_cycles", 64'(vld_cnt - v0), 64'd2);
    chk("t6_queue_empty", 64'(expq.size()), 64'd0);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    tick();
    v0 = vld_cnt;
    go(1'b0);
    chk("t6_zero_done", {63'd0, done}, 64'd1);
    chk("t6_zero_busy", {63'd0, busy}, 64'd0);
    go(1'b1);
    repeat (3) tick();
    chk("t6_zero_cont_busy", {63'd0, busy}, 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_zero_cont_done", {63'd0, done}, 64'd1);
    chk("t6_zero_no_valid", 64'(vld_cnt - v0), 64'd0);
`else
    for (int i = 0; i < NREG; i++) push(i, model[i]);
    go(1'b0);
    chk("t6_first_sel", {61'd0, sel}, 64'd0);
    wait_done(20, "t6_done_timeout");
    tick();
    chk("t6_vld_cycles", 64'(vld_cnt - v0), 64'd8);
    chk("t6_queue_empty", 64'(expq.size()), 64'd0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
